// File: rtl/control_pkg.sv
// Shared write-back control definitions: opcodes, FSM states, op classes.
package control_pkg;

    localparam logic [3:0] I_LOAD  = 4'd0;
    localparam logic [3:0] I_STOP  = 4'd1;
    localparam logic [3:0] I_STORE = 4'd2;
    localparam logic [3:0] I_ADD   = 4'd4;
    localparam logic [3:0] I_SUB   = 4'd6;
    localparam logic [3:0] I_NAND  = 4'd8;
    localparam logic [3:0] I_NOP   = 4'd10;
    localparam logic [2:0] I_SHIFT = 3'd3;
    localparam logic [2:0] I_ORI   = 3'd7;

    localparam logic [1:0] R1 = 2'd1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        HALT     = 2'd2
    } state_t;

    typedef struct packed {
        logic alu;
        logic shift;
        logic ori;
        logic load;
        logic store;
        logic stop;
        logic nop;
    } op_class_t;

endpackage

// File: rtl/control_decode.sv
// One-hot opcode classifier; 3-bit shift/ori patterns win over 4-bit opcodes.
module control_decode
    import control_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        unique case (1'b1)
            opcode[2:0] == I_SHIFT: cls.shift = 1'b1;
            opcode[2:0] == I_ORI:   cls.ori   = 1'b1;
            opcode == I_LOAD:       cls.load  = 1'b1;
            opcode == I_STOP:       cls.stop  = 1'b1;
            opcode == I_STORE:      cls.store = 1'b1;
            opcode == I_ADD,
            opcode == I_SUB,
            opcode == I_NAND:       cls.alu   = 1'b1;
            opcode == I_NOP:        cls.nop   = 1'b1;
            default:                cls.nop   = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_write.sv
// Write-back stage controller: strobes, load stall/timeout, halt latch.
// Optional CONTROL_WRITE_PERF_EN adds a 16-bit retired-instruction counter.
module control_write
    import control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en_write,
    input  logic [7:0] instr,
    input  logic       mem_valid,
    output logic       rf_write,
    output logic [1:0] rf_waddr,
    output logic       wb_sel,
    output logic       flag_load,
    output logic       mem_write,
    output logic       stall,
    output logic       halted,
    output logic       mem_err
`ifdef CONTROL_WRITE_PERF_EN
    ,
    output logic [15:0] retire_count
`endif
);

    state_t     state;
    op_class_t  cls;
    logic [7:0] cnt;
    logic [1:0] rx_q;
    logic [1:0] rx;
    logic       unused_bits;

    assign rx          = instr[7:6];
    assign unused_bits = ^instr[5:4];

    control_decode u_decode (
        .opcode (instr[3:0]),
        .cls    (cls)
    );

    always_comb begin
        rf_write  = 1'b0;
        rf_waddr  = 2'd0;
        wb_sel    = 1'b0;
        flag_load = 1'b0;
        mem_write = 1'b0;
        stall     = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: if (en_write) begin
                    unique case (1'b1)
                        cls.alu, cls.shift: begin
                            rf_write  = 1'b1;
                            rf_waddr  = rx;
                            flag_load = 1'b1;
                        end
                        cls.ori: begin
                            rf_write  = 1'b1;
                            rf_waddr  = R1;
                            flag_load = 1'b1;
                        end
                        cls.load: begin
                            if (mem_valid) begin
                                rf_write = 1'b1;
                                rf_waddr = rx;
                                wb_sel   = 1'b1;
                            end else begin
                                stall = 1'b1;
                            end
                        end
                        cls.store: mem_write = 1'b1;
                        cls.stop:  stall = 1'b1;
                        default: ;
                    endcase
                end
                WAIT_MEM: begin
                    if (mem_valid) begin
                        rf_write = 1'b1;
                        rf_waddr = rx_q;
                        wb_sel   = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
                HALT: stall = 1'b1;
                default: ;
            endcase
        end
    end

    // A timeout of 1 leaves only the issuing cycle to catch the data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            cnt     <= 8'd0;
            rx_q    <= 2'd0;
            halted  <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            unique case (state)
                RUN: if (en_write) begin
                    if (cls.load && !mem_valid) begin
                        rx_q <= rx;
                        cnt  <= 8'd0;
                        if (MEM_TIMEOUT == 1) begin
                            state   <= HALT;
                            halted  <= 1'b1;
                            mem_err <= 1'b1;
                        end else begin
                            state <= WAIT_MEM;
                        end
                    end else if (cls.stop) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                WAIT_MEM: begin
                    if (mem_valid) begin
                        state <= RUN;
                    end else if (cnt == 8'(MEM_TIMEOUT - 2)) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HALT: ;
                default: state <= RUN;
            endcase
        end
    end

`ifdef CONTROL_WRITE_PERF_EN
    logic retire;

    assign retire = !reset &&
        ((state == RUN && en_write && !(cls.load && !mem_valid)) ||
         (state == WAIT_MEM && mem_valid));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            retire_count <= 16'd0;
        else if (retire)
            retire_count <= retire_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_control_write.sv
// Scoreboard bench for control_write: driver queues expectations,
// a negedge monitor pops and compares the observed outputs.
module tb_control_write;
    import control_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en_write = 1'b0;
    logic [7:0] instr = 8'd0;
    logic       mem_valid = 1'b0;
    logic       rf_write;
    logic [1:0] rf_waddr;
    logic       wb_sel;
    logic       flag_load;
    logic       mem_write;
    logic       stall;
    logic       halted;
    logic       mem_err;
`ifdef CONTROL_WRITE_PERF_EN
    logic [15:0] retire_count;
`endif

    typedef struct packed {
        logic       rf_write;
        logic [1:0] rf_waddr;
        logic       wb_sel;
        logic       flag_load;
        logic       mem_write;
        logic       stall;
        logic       halted;
        logic       mem_err;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    obs_t  act;
    obs_t  e_cur;
    string n_cur;
    int    checks = 0;
    int    passed = 0;

    always #5 clock = ~clock;

    control_write #(.MEM_TIMEOUT(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .en_write  (en_write),
        .instr     (instr),
        .mem_valid (mem_valid),
        .rf_write  (rf_write),
        .rf_waddr  (rf_waddr),
        .wb_sel    (wb_sel),
        .flag_load (flag_load),
        .mem_write (mem_write),
        .stall     (stall),
        .halted    (halted),
        .mem_err   (mem_err)
`ifdef CONTROL_WRITE_PERF_EN
        ,
        .retire_count (retire_count)
`endif
    );

    assign act = {rf_write, rf_waddr, wb_sel, flag_load,
                  mem_write, stall, halted, mem_err};

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            e_cur = exp_q.pop_front();
            n_cur = name_q.pop_front();
            checks++;
            if (act === e_cur)
                passed++;
            else
                $display("FAIL %s: got rw/wa/wb/fl/mw/st/h/me=%b expected %b",
                         n_cur, act, e_cur);
        end
    end

    function automatic obs_t o(input logic rw, input logic [1:0] wa,
                               input logic wb, input logic fl,
                               input logic mw, input logic st,
                               input logic h, input logic me);
        return {rw, wa, wb, fl, mw, st, h, me};
    endfunction

    task automatic step(input logic r, input logic en, input logic [7:0] i,
                        input logic mv, input obs_t e, input string n);
        @(posedge clock);
        #1;
        reset     = r;
        en_write  = en;
        instr     = i;
        mem_valid = mv;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    localparam logic [7:0] ADD  = 8'b10_01_0100;
    localparam logic [7:0] LD3  = 8'b11_00_0000;

    initial begin
        // reset and basic decode
        step(1, 1, ADD, 1, o(0,0,0,0,0,0,0,0), "reset_state");
        step(0, 1, ADD, 0, o(1,2,0,1,0,0,0,0), "add");
        step(0, 1, 8'b00110_111, 0, o(1,1,0,1,0,0,0,0), "ori");
        step(0, 1, 8'b00_01_0010, 0, o(0,0,0,0,1,0,0,0), "store");
        step(0, 0, 8'b00_01_0010, 0, o(0,0,0,0,0,0,0,0), "store_one_cycle");
        step(0, 1, 8'b01_00_0110, 0, o(1,1,0,1,0,0,0,0), "sub");
        step(0, 1, 8'b11_00_1000, 0, o(1,3,0,1,0,0,0,0), "nand");
        step(0, 1, 8'b10_00_1011, 0, o(1,2,0,1,0,0,0,0), "shift11");
        step(0, 1, 8'b01_00_1111, 0, o(1,1,0,1,0,0,0,0), "ori15");
        step(0, 1, 8'h0A, 0, o(0,0,0,0,0,0,0,0), "nop");
        step(0, 1, 8'hC5, 0, o(0,0,0,0,0,0,0,0), "undef5");
        step(0, 1, 8'hCC, 1, o(0,0,0,0,0,0,0,0), "undef12");
        step(0, 1, 8'b01_00_0000, 1, o(1,1,1,0,0,0,0,0), "load_hit");
        step(0, 0, 8'b01_00_0000, 1, o(0,0,0,0,0,0,0,0), "stray_valid");

        // load with three low cycles of mem_valid
        step(0, 1, LD3, 0, o(0,0,0,0,0,1,0,0), "ld_wait0");
        step(0, 1, ADD, 0, o(0,0,0,0,0,1,0,0), "ld_wait1");
        step(0, 1, ADD, 0, o(0,0,0,0,0,1,0,0), "ld_wait2");
        step(0, 1, ADD, 1, o(1,3,1,0,0,0,0,0), "ld_done");
        step(0, 1, ADD, 0, o(1,2,0,1,0,0,0,0), "add_after_ld");

        // reset in the middle of a wait
        step(0, 1, LD3, 0, o(0,0,0,0,0,1,0,0), "rw_wait0");
        step(0, 1, ADD, 0, o(0,0,0,0,0,1,0,0), "rw_wait1");
        step(1, 1, ADD, 1, o(0,0,0,0,0,0,0,0), "rw_reset");
        step(0, 1, ADD, 0, o(1,2,0,1,0,0,0,0), "rw_add");
        step(0, 0, ADD, 0, o(0,0,0,0,0,0,0,0), "rw_idle");
`ifdef CONTROL_WRITE_PERF_EN
        #2;
        checks++;
        if (retire_count === 16'd1)
            passed++;
        else
            $display("FAIL retire_count: got %0d expected 1", retire_count);
`endif

        // timeout: 15 stalled cycles, then halt with error
        step(0, 1, LD3, 0, o(0,0,0,0,0,1,0,0), "to_issue");
        for (int k = 1; k < 15; k++)
            step(0, 1, ADD, 0, o(0,0,0,0,0,1,0,0), $sformatf("to_wait%0d", k));
        step(0, 1, ADD, 0, o(0,0,0,0,0,1,1,1), "to_halt");
        step(0, 1, ADD, 1, o(0,0,0,0,0,1,1,1), "to_halt_sticky");
        step(1, 1, ADD, 1, o(0,0,0,0,0,0,0,0), "to_reset");

        // stop
        step(0, 1, 8'h01, 0, o(0,0,0,0,0,1,0,0), "stop");
        step(0, 1, ADD, 0, o(0,0,0,0,0,1,1,0), "stop_halt");
        step(0, 1, 8'b00_01_0010, 1, o(0,0,0,0,0,1,1,0), "halt_store");
        step(1, 1, ADD, 0, o(0,0,0,0,0,0,0,0), "stop_reset");
        step(0, 1, ADD, 0, o(1,2,0,1,0,0,0,0), "add_after_stop");

        repeat (3) @(posedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
